// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM and IF/ID register
// Redirects override stalls; a stale in-flight response is dropped via drop.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcSrc,
  input  logic        jORb,
  input  logic        pcWrite,
  input  logic        ifidWrite,
  input  logic        ifidFlush,
  input  logic [31:0] branchAddr,
  input  logic [31:0] jumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] ID_INS,
  output logic [31:0] ID_PC4,
  output logic        ID_valid,
  output logic        fetch_busy,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic        drop;
  logic [31:0] pc;
  logic [31:0] buffer;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        load_ok;
  logic        do_load;
  logic [31:0] load_word;

  assign target     = jORb ? branchAddr : jumpAddr;
  assign pc_plus4   = pc + 32'd4;
  assign load_ok    = pcWrite && ifidWrite && !ifidFlush && !pcSrc;
  assign do_load    = load_ok && (((state == S_WAIT) && imem_ready && !drop) || (state == S_HOLD));
  assign load_word  = (state == S_HOLD) ? buffer : imem_data;

  assign imem_req   = (state == S_REQ) && !rst;
  assign imem_addr  = pc;
  assign fetch_busy = (state == S_WAIT) || (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      drop        <= 1'b0;
      pc          <= 32'd0;
      buffer      <= 32'd0;
      ID_INS      <= 32'd0;
      ID_PC4      <= 32'd0;
      ID_valid    <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        S_REQ: begin
          state <= S_WAIT;
          if (pcSrc) begin
            pc   <= target;
            drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!imem_ready) begin
            if (pcSrc) begin
              pc   <= target;
              drop <= 1'b1;
            end
          end else if (pcSrc) begin
            pc    <= target;
            drop  <= 1'b0;
            state <= S_REQ;
          end else if (drop) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else if (load_ok) begin
            pc    <= pc_plus4;
            state <= S_REQ;
          end else begin
            buffer <= imem_data;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (pcSrc) begin
            pc    <= target;
            state <= S_REQ;
          end else if (load_ok) begin
            pc    <= pc_plus4;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      // Flush wins over any load; load_ok already excludes flush cycles.
      if (ifidFlush) begin
        ID_INS   <= 32'd0;
        ID_PC4   <= 32'd0;
        ID_valid <= 1'b0;
      end else if (do_load) begin
        ID_INS      <= load_word;
        ID_PC4      <= pc_plus4;
        ID_valid    <= 1'b1;
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcSrc, jORb, pcWrite, ifidWrite, ifidFlush;
  logic [31:0] branchAddr, jumpAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] ID_INS, ID_PC4;
  logic        ID_valid, fetch_busy;
  logic [15:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .pcSrc(pcSrc), .jORb(jORb), .pcWrite(pcWrite),
    .ifidWrite(ifidWrite), .ifidFlush(ifidFlush), .branchAddr(branchAddr),
    .jumpAddr(jumpAddr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .ID_INS(ID_INS),
    .ID_PC4(ID_PC4), .ID_valid(ID_valid), .fetch_busy(fetch_busy),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pcSrc = 1'b0; jORb = 1'b0; pcWrite = 1'b1; ifidWrite = 1'b1;
    ifidFlush = 1'b0; branchAddr = 32'd0; jumpAddr = 32'd0;
    imem_ready = 1'b0; imem_data = 32'd0;
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_ins", ID_INS, 32'd0);
    check("rst_valid", {31'd0, ID_valid}, 32'd0);
    check("rst_count", {16'd0, fetch_count}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);

    // Two back-to-back fetches with latency 1
    rst = 1'b0; #1;
    check("req0", {31'd0, imem_req}, 32'd1);
    tick();
    check("wait_busy", {31'd0, fetch_busy}, 32'd1);
    check("wait_noreq", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1; imem_data = 32'h11;
    tick();
    imem_ready = 1'b0;
    check("f1_ins", ID_INS, 32'h11);
    check("f1_pc4", ID_PC4, 32'h4);
    check("f1_valid", {31'd0, ID_valid}, 32'd1);
    check("f1_addr", imem_addr, 32'h4);
    tick();
    imem_ready = 1'b1; imem_data = 32'h22;
    tick();
    imem_ready = 1'b0;
    check("f2_ins", ID_INS, 32'h22);
    check("f2_pc4", ID_PC4, 32'h8);
    check("f2_count", {16'd0, fetch_count}, 32'd2);
    check("f2_addr", imem_addr, 32'h8);

    // Stall at response: HOLD for 3 cycles, then release
    tick();
    imem_ready = 1'b1; imem_data = 32'h33; pcWrite = 1'b0;
    tick();
    imem_ready = 1'b0;
    check("hold_busy", {31'd0, fetch_busy}, 32'd1);
    check("hold_ins", ID_INS, 32'h22);
    tick(); tick();
    check("hold_ins3", ID_INS, 32'h22);
    check("hold_addr", imem_addr, 32'h8);
    pcWrite = 1'b1;
    tick();
    check("rel_ins", ID_INS, 32'h33);
    check("rel_pc4", ID_PC4, 32'hC);
    check("rel_addr", imem_addr, 32'hC);
    check("rel_count", {16'd0, fetch_count}, 32'd3);

    // Branch while waiting: stale response must be dropped
    tick();
    pcSrc = 1'b1; jORb = 1'b1; branchAddr = 32'h40;
    tick();
    pcSrc = 1'b0;
    check("br_busy", {31'd0, fetch_busy}, 32'd1);
    imem_ready = 1'b1; imem_data = 32'hBAD;
    tick();
    imem_ready = 1'b0;
    check("br_ins", ID_INS, 32'h33);
    check("br_count", {16'd0, fetch_count}, 32'd3);
    check("br_req", {31'd0, imem_req}, 32'd1);
    check("br_addr", imem_addr, 32'h40);

    // Jump plus flush coincident with response
    tick();
    pcSrc = 1'b1; jORb = 1'b0; jumpAddr = 32'h100; ifidFlush = 1'b1;
    imem_ready = 1'b1; imem_data = 32'h44;
    tick();
    pcSrc = 1'b0; ifidFlush = 1'b0; imem_ready = 1'b0;
    check("fl_ins", ID_INS, 32'd0);
    check("fl_pc4", ID_PC4, 32'd0);
    check("fl_valid", {31'd0, ID_valid}, 32'd0);
    check("fl_addr", imem_addr, 32'h100);
    check("fl_count", {16'd0, fetch_count}, 32'd3);

    // Reset mid-fetch with a valid IF/ID
    tick();
    imem_ready = 1'b1; imem_data = 32'h55;
    tick();
    imem_ready = 1'b0;
    check("pre_ins", ID_INS, 32'h55);
    check("pre_pc4", ID_PC4, 32'h104);
    tick();
    check("pre_valid", {31'd0, ID_valid}, 32'd1);
    rst = 1'b1; imem_ready = 1'b1; imem_data = 32'h99;
    tick();
    imem_ready = 1'b0;
    check("mrst_req", {31'd0, imem_req}, 32'd0);
    check("mrst_ins", ID_INS, 32'd0);
    check("mrst_pc4", ID_PC4, 32'd0);
    check("mrst_valid", {31'd0, ID_valid}, 32'd0);
    check("mrst_count", {16'd0, fetch_count}, 32'd0);
    check("mrst_busy", {31'd0, fetch_busy}, 32'd0);
    rst = 1'b0; #1;
    check("post_req", {31'd0, imem_req}, 32'd1);
    check("post_addr", imem_addr, 32'd0);
    imem_ready = 1'b1; imem_data = 32'h66;
    tick();
    imem_ready = 1'b0;
    check("post_ign", {31'd0, ID_valid}, 32'd0);
    imem_ready = 1'b1; imem_data = 32'h77;
    tick();
    imem_ready = 1'b0;
    check("post_ins", ID_INS, 32'h77);
    check("post_pc4", ID_PC4, 32'h4);

    // PC wrap: jump to 0xFFFFFFFC, fetch once
    pcSrc = 1'b1; jORb = 1'b0; jumpAddr = 32'hFFFF_FFFC;
    tick();
    pcSrc = 1'b0; imem_ready = 1'b1; imem_data = 32'hDEAD;
    tick();
    imem_ready = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    check("wr_ins0", ID_INS, 32'h77);
    tick();
    imem_ready = 1'b1; imem_data = 32'h88;
    tick();
    imem_ready = 1'b0;
    check("wr_ins", ID_INS, 32'h88);
    check("wr_pc4", ID_PC4, 32'd0);
    check("wr_addr2", imem_addr, 32'd0);
    check("wr_count", {16'd0, fetch_count}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
